// File: rtl/operand_skid_buffer.sv
// Two-entry valid/ready skid buffer staging one operand bundle (A, B, C, ctrl)
// ahead of the combinational select stage. The head register always drives the
// outputs. The tail register only absorbs a push that arrives while the head
// is stalled.
module operand_skid_buffer #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         IN_valid,
    output logic         OUT_ready,
    input  logic [N-1:0] IN_valA,
    input  logic [N-1:0] IN_valB,
    input  logic [N-1:0] IN_valC,
    input  logic         IN_ctrl,
    output logic         OUT_valid,
    input  logic         IN_ready,
    output logic [N-1:0] OUT_valA,
    output logic [N-1:0] OUT_valB,
    output logic [N-1:0] OUT_valC,
    output logic         OUT_ctrl,
    output logic [1:0]   OUT_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic         ctrl;
        logic [N-1:0] c;
        logic [N-1:0] b;
        logic [N-1:0] a;
    } bundle_t;

    state_t  state_q, state_d;
    bundle_t head_q, head_d;
    bundle_t tail_q, tail_d;
    bundle_t in_bundle;
    logic    push;
    logic    pop;

    assign in_bundle = '{ctrl: IN_ctrl, c: IN_valC, b: IN_valB, a: IN_valA};

    // Handshake flags are decoded purely from the state register, so neither
    // ready nor valid has a combinational path from the opposite-side inputs.
    assign OUT_ready = (state_q != ST_FULL);
    assign OUT_valid = (state_q != ST_EMPTY);
    assign OUT_count = state_q;
    assign OUT_valA  = head_q.a;
    assign OUT_valB  = head_q.b;
    assign OUT_valC  = head_q.c;
    assign OUT_ctrl  = head_q.ctrl;

    assign push = IN_valid && OUT_ready;
    assign pop  = OUT_valid && IN_ready;

    // Next-state and entry-register update for each occupancy level.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = in_bundle;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d  = in_bundle;
                end else if (push) begin
                    tail_d  = in_bundle;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and entry registers; reset empties the buffer and clears all data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
